// File: rtl/alu_seq_if.sv
// Handshake and operand/result bundle for alu_seq: the producer side drives operands,
// the consumer side drives out_ready, and the ALU drives in_ready/out_valid/c.
interface alu_seq_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic [3:0]      aluOP;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] c;

  modport master (
    output in_valid, a, b, aluOP, out_ready,
    input  in_ready, out_valid, c
  );

  modport slave (
    input  in_valid, a, b, aluOP, out_ready,
    output in_ready, out_valid, c
  );
endinterface

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle logic/arith/shift ops and an iterative shift-add
// multiplier (one multiplier bit per cycle), with a valid/ready result handshake.
module alu_seq #(
  parameter int XLEN = 32
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      flush,
  alu_seq_if.slave  bus
);
  localparam int SHW = $clog2(XLEN);

  localparam logic [3:0] OP_AND  = 4'd0;
  localparam logic [3:0] OP_OR   = 4'd1;
  localparam logic [3:0] OP_ADD  = 4'd2;
  localparam logic [3:0] OP_SUB  = 4'd3;
  localparam logic [3:0] OP_SLT  = 4'd4;
  localparam logic [3:0] OP_SLTU = 4'd5;
  localparam logic [3:0] OP_XOR  = 4'd6;
  localparam logic [3:0] OP_SLL  = 4'd8;
  localparam logic [3:0] OP_SRA  = 4'd9;
  localparam logic [3:0] OP_SRL  = 4'd10;
  localparam logic [3:0] OP_MUL  = 4'd11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nx;
  logic            in_ready_c;
  logic            out_valid_c;
  logic            accept;
  logic            is_mul;
  logic            mul_last;
  logic [XLEN-1:0] mcand;
  logic [XLEN-1:0] mplier;
  logic [XLEN-1:0] acc;
  logic [XLEN-1:0] partial;
  logic [XLEN-1:0] c_q;
  logic [SHW-1:0]  cnt;

  // Single-cycle ops; undefined opcodes (and MUL, handled by the iterator) yield zero.
  function automatic logic [XLEN-1:0] alu_result(
    input logic [3:0]      op,
    input logic [XLEN-1:0] x,
    input logic [XLEN-1:0] y
  );
    logic signed [XLEN-1:0] xs;
    logic signed [XLEN-1:0] ys;
    logic [SHW-1:0]         sh;
    xs = x;
    ys = y;
    sh = y[SHW-1:0];
    alu_result = '0;
    case (op)
      OP_AND:  alu_result = x & y;
      OP_OR:   alu_result = x | y;
      OP_ADD:  alu_result = x + y;
      OP_SUB:  alu_result = x - y;
      OP_SLT:  alu_result = {{(XLEN-1){1'b0}}, (xs < ys)};
      OP_SLTU: alu_result = {{(XLEN-1){1'b0}}, (x < y)};
      OP_XOR:  alu_result = x ^ y;
      OP_SLL:  alu_result = x << sh;
      OP_SRA:  alu_result = xs >>> sh;
      OP_SRL:  alu_result = x >> sh;
      default: alu_result = '0;
    endcase
  endfunction

  assign is_mul   = (bus.aluOP == OP_MUL);
  assign accept   = bus.in_valid && in_ready_c && !flush;
  assign mul_last = (state == S_MUL) && (cnt == SHW'(XLEN-1));
  assign partial  = acc + (mplier[0] ? mcand : '0);

  // ---- state register ----
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  // ---- next-state logic ----
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: begin
        if (accept) state_nx = is_mul ? S_MUL : S_DONE;
      end
      S_MUL: begin
        if (mul_last) state_nx = S_DONE;
      end
      S_DONE: begin
        if (accept)             state_nx = is_mul ? S_MUL : S_DONE;
        else if (bus.out_ready) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
    if (flush) state_nx = S_IDLE;
  end

  // ---- outputs decoded from state ----
  always_comb begin
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    case (state)
      S_IDLE: in_ready_c = 1'b1;
      S_DONE: begin
        in_ready_c  = bus.out_ready;
        out_valid_c = 1'b1;
      end
      default: begin
        in_ready_c  = 1'b0;
        out_valid_c = 1'b0;
      end
    endcase
  end

  // ---- operand capture, multiply iteration and result register ----
  // The product is written straight into c on the last iteration, so DONE always
  // presents c regardless of which path produced it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      c_q    <= '0;
    end else if (flush) begin
      cnt    <= '0;
    end else if (accept) begin
      mcand  <= bus.a;
      mplier <= bus.b;
      acc    <= '0;
      cnt    <= '0;
      if (!is_mul) c_q <= alu_result(bus.aluOP, bus.a, bus.b);
    end else if (state == S_MUL) begin
      acc    <= partial;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + SHW'(1);
      if (mul_last) c_q <= partial;
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.c         = c_q;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: a transaction-level model (result value plus a
// multiply countdown) is checked every cycle, alongside directed literal cases.
module tb_alu_seq;
  logic clk = 1'b0;
  logic rst_n;
  logic flush;
  int   n_cmp = 0;
  int   n_err = 0;
  bit   chk_en = 1'b0;

  alu_seq_if #(.XLEN(32)) bus ();

  alu_seq #(.XLEN(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  bit          m_valid = 1'b0;
  logic [31:0] m_c = '0;
  int          m_mul_left = 0;
  logic [31:0] m_mul_res = '0;

  function automatic logic [31:0] ref_op(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
    int sh;
    sh = int'(y % 32);
    case (op)
      4'd0:  return x & y;
      4'd1:  return x | y;
      4'd2:  return x + y;
      4'd3:  return x - y;
      4'd4:  return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      4'd5:  return (x < y) ? 32'd1 : 32'd0;
      4'd6:  return x ^ y;
      4'd8:  return x << sh;
      4'd9:  return 32'($signed(x) >>> sh);
      4'd10: return x >> sh;
      4'd11: return x * y;
      default: return 32'd0;
    endcase
  endfunction

  function automatic bit model_ready();
    return (m_mul_left == 0) && (!m_valid || bus.out_ready);
  endfunction

  always @(posedge clk) begin
    bit acc;
    if (!rst_n) begin
      m_valid = 1'b0; m_c = '0; m_mul_left = 0;
    end else if (flush) begin
      m_valid = 1'b0; m_mul_left = 0;
    end else if (m_mul_left > 0) begin
      m_mul_left--;
      if (m_mul_left == 0) begin m_valid = 1'b1; m_c = m_mul_res; end
    end else begin
      acc = bus.in_valid && model_ready();
      if (m_valid && bus.out_ready) m_valid = 1'b0;
      if (acc) begin
        if (bus.aluOP == 4'd11) begin
          m_mul_left = 32;
          m_mul_res  = ref_op(4'd11, bus.a, bus.b);
        end else begin
          m_valid = 1'b1;
          m_c     = ref_op(bus.aluOP, bus.a, bus.b);
        end
      end
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // ---------------- per-cycle compare against the model ----------------
  always begin
    @(posedge clk);
    #1;
    if (chk_en) begin
      check("model out_valid", 32'(bus.out_valid), 32'(m_valid));
      check("model in_ready", 32'(bus.in_ready), 32'(model_ready()));
      if (m_valid) check("model c", bus.c, m_c);
    end
  end

  // ---------------- directed helpers ----------------
  task automatic op1(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                     input logic [31:0] exp, input string nm);
    @(negedge clk);
    bus.in_valid = 1'b1; bus.aluOP = op; bus.a = x; bus.b = y; bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check({nm, " valid"}, 32'(bus.out_valid), 32'd1);
    check(nm, bus.c, exp);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    end
  endtask

  task automatic mul_chk(input logic [31:0] x, input logic [31:0] y, input logic [31:0] exp, input string nm);
    int cyc;
    int nlow;
    @(negedge clk);
    bus.in_valid = 1'b1; bus.aluOP = 4'd11; bus.a = x; bus.b = y; bus.out_ready = 1'b1;
    @(posedge clk); #1;
    cyc = 1; nlow = 0;
    while (!bus.out_valid && cyc < 100) begin
      if (!bus.in_ready) nlow++;
      @(negedge clk); bus.in_valid = 1'b0;
      @(posedge clk); #1;
      cyc++;
    end
    check({nm, " latency"}, 32'(cyc), 32'd33);
    check({nm, " busy cycles"}, 32'(nlow), 32'd32);
    check(nm, bus.c, exp);
  endtask

  function automatic logic [31:0] rnd_val();
    case ($urandom % 6)
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    int hi;
    logic [3:0] op;
    rst_n = 1'b0; flush = 1'b0;
    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.aluOP = '0; bus.out_ready = 1'b1;

    // Pin the model to hand-computed values.
    check("ref ADD wrap", ref_op(4'd2, 32'h7FFF_FFFF, 32'd1), 32'h8000_0000);
    check("ref SRA", ref_op(4'd9, 32'h8000_0000, 32'h21), 32'hC000_0000);
    check("ref MUL", ref_op(4'd11, 32'h0000_FFFF, 32'h0001_0001), 32'hFFFF_FFFF);
    check("ref op13", ref_op(4'd13, 32'h1234_5678, 32'h1), 32'h0);

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk_en = 1'b1;
    #1;
    check("reset out_valid", 32'(bus.out_valid), 32'd0);
    check("reset c", bus.c, 32'd0);
    check("reset in_ready", 32'(bus.in_ready), 32'd1);

    op1(4'd2,  32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, "ADD overflow");
    op1(4'd4,  32'h7FFF_FFFF, 32'h0000_0001, 32'h0000_0000, "SLT");
    op1(4'd5,  32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0001, "SLTU");
    op1(4'd9,  32'h8000_0000, 32'h0000_0021, 32'hC000_0000, "SRA");
    op1(4'd10, 32'h8000_0000, 32'h0000_0021, 32'h4000_0000, "SRL");
    op1(4'd8,  32'h0000_0001, 32'h0000_003F, 32'h8000_0000, "SLL");
    op1(4'd3,  32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, "SUB wrap");
    idle(1);

    mul_chk(32'h0000_FFFF, 32'h0001_0001, 32'hFFFF_FFFF, "MUL a");
    mul_chk(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, "MUL b");
    idle(2);

    // Backpressure then back-to-back XOR.
    @(negedge clk);
    bus.in_valid = 1'b1; bus.aluOP = 4'd2; bus.a = 32'd5; bus.b = 32'd7; bus.out_ready = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); bus.in_valid = 1'b0; bus.a = $urandom; bus.b = $urandom;
      @(posedge clk); #1;
      check("hold out_valid", 32'(bus.out_valid), 32'd1);
      check("hold c", bus.c, 32'd12);
    end
    @(negedge clk);
    bus.out_ready = 1'b1; bus.in_valid = 1'b1; bus.aluOP = 4'd6;
    bus.a = 32'hF0F0_F0F0; bus.b = 32'h0FF0_0FF0;
    #1;
    check("b2b in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    check("b2b XOR valid", 32'(bus.out_valid), 32'd1);
    check("b2b XOR c", bus.c, 32'hFF00_FF00);
    idle(2);

    // Flush ten cycles into a multiply.
    @(negedge clk);
    bus.in_valid = 1'b1; bus.aluOP = 4'd11; bus.a = 32'd3; bus.b = 32'd9;
    repeat (9) begin @(negedge clk); bus.in_valid = 1'b0; end
    @(negedge clk); flush = 1'b1;
    @(posedge clk); #1;
    check("flush out_valid", 32'(bus.out_valid), 32'd0);
    check("flush in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk); flush = 1'b0;
    hi = 0;
    repeat (40) begin @(posedge clk); #1; if (bus.out_valid) hi++; end
    check("flushed MUL silent", 32'(hi), 32'd0);

    // Reset mid-multiply, then in DONE, then an undefined opcode.
    @(negedge clk);
    bus.in_valid = 1'b1; bus.aluOP = 4'd11; bus.a = 32'd3; bus.b = 32'd9;
    repeat (5) begin @(negedge clk); bus.in_valid = 1'b0; end
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("rst MUL out_valid", 32'(bus.out_valid), 32'd0);
    check("rst MUL c", bus.c, 32'd0);
    check("rst MUL in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk); rst_n = 1'b1;
    bus.in_valid = 1'b1; bus.aluOP = 4'd1; bus.a = 32'h55; bus.b = 32'hAA0; bus.out_ready = 1'b0;
    @(negedge clk); bus.in_valid = 1'b0; rst_n = 1'b0;
    @(posedge clk); #1;
    check("rst DONE out_valid", 32'(bus.out_valid), 32'd0);
    check("rst DONE c", bus.c, 32'd0);
    check("rst DONE in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk); rst_n = 1'b1;
    op1(4'd2, 32'd1, 32'd1, 32'd2, "pre-undef ADD");
    op1(4'd13, 32'h1234_5678, 32'h9ABC_DEF0, 32'd0, "undef op13");
    op1(4'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, "undef op7");
    idle(2);

    // Randomized traffic checked by the model every cycle.
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      op = 4'($urandom_range(0, 15));
      if (op == 4'd11 && ($urandom % 3) != 0) op = 4'd2;
      bus.in_valid  = ($urandom % 3) != 0;
      bus.aluOP     = op;
      bus.a         = rnd_val();
      bus.b         = rnd_val();
      bus.out_ready = ($urandom % 4) != 0;
      flush         = ($urandom % 80) == 0;
      rst_n         = ($urandom % 250) != 0;
    end
    @(negedge clk);
    flush = 1'b0; rst_n = 1'b1;
    idle(40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter XLEN, default 32, operand/result width; SHALL be a power of two, 8..64.
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge only.
REQ-003 rst_n  input  1  reset, synchronous and active-low; sampled only on rising clk.
REQ-004 flush  input  1  synchronous cancel of any operation held or in progress.
REQ-005 in_valid  input  1  operands and opcode are valid this cycle.
REQ-006 in_ready  output  1  block accepts a new operation this cycle.
REQ-007 a  input  XLEN  operand A.
REQ-008 b  input  XLEN  operand B; shift amount for shift ops.
REQ-009 aluOP  input  4  operation select.
REQ-010 out_valid  output  1  c holds a completed result.
REQ-011 out_ready  input  1  consumer takes c this cycle.
REQ-012 c  output  XLEN  registered result.

Function
REQ-013 Accept SHALL occur on a rising edge where in_valid=1, in_ready=1 and flush=0; a, b and aluOP SHALL be captured at that edge.
REQ-014 Opcodes: 0 AND; 1 bitwise OR; 2 ADD; 3 SUB; 4 SLT signed (result 1 or 0); 5 SLTU unsigned; 6 XOR; 8 SLL; 9 SRA; 10 SRL; 11 MUL.
REQ-015 ADD, SUB and MUL results SHALL be truncated to XLEN bits, two's-complement wrap, no overflow flag.
REQ-016 Shift ops SHALL use only the low log2(XLEN) bits of b; upper bits ignored.
REQ-017 Opcodes 7 and 12..15 SHALL complete with c=0 and single-op latency.
REQ-018 States: IDLE, MUL, DONE.
REQ-019 IDLE: accept of a non-MUL op -> DONE with c=result at the accept edge; out_valid=1 the following cycle (latency 1).
REQ-020 IDLE: accept of MUL -> MUL with iteration counter=0; multiplication SHALL be iterative shift-add, one bit of b per cycle.
REQ-021 MUL: counter increments each edge; after exactly XLEN iteration edges -> DONE with c = low XLEN bits of a*b; out_valid observed XLEN+1 cycles after the accept cycle.
REQ-022 DONE: c and out_valid SHALL hold stable while out_ready=0.
REQ-023 DONE with out_ready=1 and no accept -> IDLE, out_valid=0.
REQ-024 in_ready SHALL be 1 in IDLE, 1 in DONE when out_ready=1, else 0; in MUL in_ready=0.
REQ-025 DONE with out_ready=1 and simultaneous accept: current result SHALL be consumed and new op SHALL start the same edge (back-to-back, no bubble for non-MUL ops).
REQ-026 flush=1 SHALL force IDLE, out_valid=0, counter=0 at that edge regardless of state, and SHALL block any accept in that cycle.
REQ-027 out_valid SHALL never assert for an operation cancelled by flush or reset.
REQ-028 Inputs a, b, aluOP SHALL be ignored in MUL and when not accepted.

Reset
REQ-029 rst_n=0 at a rising edge SHALL set state IDLE, out_valid=0, c=0, counter=0, internal operand registers=0.
REQ-030 Reset SHALL take priority over flush and accept; reset mid-MUL SHALL discard the product.
REQ-031 in_ready SHALL be 1 on the first cycle after reset release.

Verification
REQ-032 XLEN=32, ADD a=0x7FFFFFFF b=0x00000001, out_ready=1 -> next cycle out_valid=1, c=0x80000000; SLT same operands -> c=0, SLTU a=0x1 b=0xFFFFFFFF -> c=1.
REQ-033 SRA a=0x80000000 b=0x00000021 -> c=0xC0000000; SRL same -> c=0x40000000; SLL a=0x1 b=0x3F -> c=0x80000000.
REQ-034 MUL a=0x0000FFFF b=0x00010001 -> in_ready=0 for 32 cycles, out_valid 33 cycles after accept, c=0xFFFFFFFF; MUL 0xFFFFFFFF*0xFFFFFFFF -> c=0x00000001.
REQ-035 Backpressure: ADD result with out_ready=0 for 5 cycles -> c and out_valid stable; then out_ready=1 with new XOR in_valid -> XOR result valid next cycle, no bubble.
REQ-036 flush asserted 10 cycles into a MUL -> next cycle state IDLE, out_valid=0, in_ready=1; no result ever emitted for that MUL.
REQ-037 rst_n=0 mid-MUL and while in DONE -> next cycle out_valid=0, c=0, in_ready=1; undefined opcode 13 afterwards -> c=0 after 1 cycle.
